// File: rtl/cpu_trace_unit.sv
// rtl/cpu_trace_unit.sv - run control and circular instruction trace around the 4-step cpu
// Optional feature macro: TRACE_TIMESTAMP_EN (per-record cycle timestamp in trace_rd_data MSBs).
module cpu_trace_unit #(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter int PTR_BITS = 4
) (
    input  logic                  clock_input,
    input  logic                  reset,
    input  logic [1:0]            step,
    input  logic [WIDTH-1:0]      pc,
    input  logic [WIDTH-1:0]      r1,
    input  logic [WIDTH-1:0]      mem_read_address,
    input  logic [WIDTH-1:0]      memory_result,
    output logic                  cpu_clock_enable,
    input  logic                  halt_req,
    input  logic                  run_req,
    input  logic                  single_step,
    input  logic                  break_en,
    input  logic [WIDTH-1:0]      break_pc,
    output logic                  halted,
    output logic                  break_hit,
    input  logic                  trace_rd_en,
`ifdef TRACE_TIMESTAMP_EN
    output logic [5*WIDTH-1:0]    trace_rd_data,
`else
    output logic [4*WIDTH-1:0]    trace_rd_data,
`endif
    output logic                  trace_rd_valid,
    output logic [PTR_BITS:0]     trace_count,
    output logic                  trace_overflow
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int REC_W = 5 * WIDTH;
`else
    localparam int REC_W = 4 * WIDTH;
`endif
    localparam logic [PTR_BITS:0] FULL_CNT = (PTR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_HALTED,
        S_LAUNCH,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic                  break_hit_q, break_hit_d;
    logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS:0]     count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [REC_W-1:0]      rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [REC_W-1:0]      trace_mem [DEPTH];

    logic                  capture;
    logic                  bp_hit;
    logic                  rd_fire;
    logic                  full;
    logic [REC_W-1:0]      record;

`ifdef TRACE_TIMESTAMP_EN
    logic [WIDTH-1:0]      ts_q, ts_d;

    always_comb begin
        ts_d = ts_q + 1'b1;
    end

    always_ff @(posedge clock_input) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign record = {ts_q, pc, r1, mem_read_address, memory_result};
`else
    assign record = {pc, r1, mem_read_address, memory_result};
`endif

    // Enable is purely a function of state and step so the cpu sees it in the same cycle.
    always_comb begin
        cpu_clock_enable = 1'b0;
        case (state_q)
            S_HALTED: cpu_clock_enable = 1'b0;
            S_LAUNCH: cpu_clock_enable = 1'b1;
            S_RUN:    cpu_clock_enable = 1'b1;
            S_DRAIN:  cpu_clock_enable = (step != 2'd3);
            default:  cpu_clock_enable = 1'b0;
        endcase
    end

    assign capture = cpu_clock_enable && (step == 2'd2);
    assign bp_hit  = break_en && capture && (pc == break_pc) && (state_q == S_RUN);

    always_comb begin
        state_d     = state_q;
        break_hit_d = break_hit_q;
        if (run_req) begin
            break_hit_d = 1'b0;
        end
        case (state_q)
            S_HALTED: begin
                if (run_req) begin
                    state_d = S_RUN;
                end else if (single_step) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (run_req && !halt_req) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_RUN: begin
                if (halt_req || bp_hit) begin
                    state_d = S_DRAIN;
                end
                if (bp_hit) begin
                    break_hit_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (run_req && !halt_req) begin
                    state_d = S_RUN;
                end else if (step == 2'd3) begin
                    state_d = S_HALTED;
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    assign rd_fire = trace_rd_en && (count_q != '0);
    assign full    = (count_q == FULL_CNT);

    // A read returns the pre-write oldest entry even when the capture lands in the same slot.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_fire;
        if (rd_fire) begin
            rd_data_d = trace_mem[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end
        if (capture) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        case ({capture, rd_fire})
            2'b10: begin
                if (full) begin
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock_input) begin
        if (reset) begin
            state_q     <= S_HALTED;
            break_hit_q <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            break_hit_q <= break_hit_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    always_ff @(posedge clock_input) begin
        if (!reset && capture) begin
            trace_mem[wr_ptr_q] <= record;
        end
    end

    assign halted         = (state_q == S_HALTED);
    assign break_hit      = break_hit_q;
    assign trace_rd_data  = rd_data_q;
    assign trace_rd_valid = rd_valid_q;
    assign trace_count    = count_q;
    assign trace_overflow = overflow_q;

endmodule
